// File: rtl/data_memory_ctrl.sv
// Word-addressed data RAM with 1-cycle registered read and write protection of the kernel words.
// An init sequencer loads two 3x3 convolution kernels into the low words and clears the rest.
module data_memory_ctrl #(
  parameter int DATA_W       = 24,
  parameter int DEPTH        = 64,
  parameter int ADDR_W       = 24,
  parameter int KERNEL_WORDS = 18,
  parameter bit PROTECT      = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_req,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd,
  output logic              rd_valid,
  output logic              ready,
  output logic              err
);

  localparam int PTR_W = $clog2(DEPTH);
  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]  KW_X     = (ADDR_W+1)'(KERNEL_WORDS);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH-1);

  typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              rd_valid_q, rd_valid_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [PTR_W-1:0]  mem_addr;
  logic [DATA_W-1:0] mem_wdat;

  logic              a_in_range;
  logic              a_kernel;
  logic              acc_vld;
  logic [PTR_W-1:0]  a_idx;

  function automatic logic [DATA_W-1:0] init_word(input logic [PTR_W-1:0] p);
    int idx;
    int v;
    idx = int'(p);
    case (idx)
      0, 2, 6, 8: v = 0;
      4:          v = 5;
      13:         v = 9;
      default:    v = (idx < KERNEL_WORDS) ? -1 : 0;
    endcase
    return DATA_W'(v);
  endfunction

  assign a_in_range = {1'b0, a} < DEPTH_X;
  assign a_kernel   = {1'b0, a} < KW_X;
  assign a_idx      = a[PTR_W-1:0];
  // init_req wins over a same-cycle request, which is dropped silently.
  assign acc_vld    = (state_q == ST_READY) && req && !init_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      ptr_q      <= '0;
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rd_q       <= rd_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_INIT) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (ptr_q == PTR_LAST) begin
        state_d = ST_READY;
        ptr_d   = '0;
      end
    end else if (init_req) begin
      state_d = ST_INIT;
      ptr_d   = '0;
    end
  end

  always_comb begin
    mem_we     = 1'b0;
    mem_addr   = ptr_q;
    mem_wdat   = init_word(ptr_q);
    rd_d       = rd_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    if (state_q == ST_INIT) begin
      mem_we = 1'b1;
    end else if (acc_vld) begin
      if (!a_in_range) begin
        rd_d  = '0;
        err_d = 1'b1;
      end else if (we && PROTECT && a_kernel) begin
        err_d = 1'b1;
      end else if (we) begin
        mem_we   = 1'b1;
        mem_addr = a_idx;
        mem_wdat = wd;
      end else begin
        rd_d       = mem[a_idx];
        rd_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdat;
    end
  end

  assign rd       = rd_q;
  assign rd_valid = rd_valid_q;
  assign err      = err_q;
  assign ready    = (state_q == ST_READY);

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench: two DUTs (PROTECT=1 and PROTECT=0) share stimulus; a queue-based
// reference model predicts each response and a negedge monitor pops and compares.
module tb_data_memory_ctrl;
  localparam int DEPTH = 64;
  localparam int KW    = 18;
  localparam int DW    = 24;
  localparam int AW    = 24;
  localparam int KERN [KW] = '{0, -1, 0, -1, 5, -1, 0, -1, 0,
                               -1, -1, -1, -1, 9, -1, -1, -1, -1};

  typedef struct {
    bit          is_err;
    bit          chk_rd;
    logic [DW-1:0] data;
  } resp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          init_req, req, we;
  logic [AW-1:0] a;
  logic [DW-1:0] wd;
  logic [DW-1:0] rd_o  [2];
  logic          rdv_o [2];
  logic          err_o [2];
  logic          rdy_o [2];

  int            n_cmp = 0;
  int            n_err = 0;
  int            busy;
  resp_t         sb_q [2][$];
  logic [DW-1:0] mdl_mem [2][DEPTH];
  logic [DW-1:0] last_rd [2];
  resp_t         e;

  always #5 clk = ~clk;

  data_memory_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .KERNEL_WORDS(KW), .PROTECT(1'b1)) u_dut_p (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .req(req), .we(we), .a(a), .wd(wd),
    .rd(rd_o[0]), .rd_valid(rdv_o[0]), .ready(rdy_o[0]), .err(err_o[0]));

  data_memory_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .KERNEL_WORDS(KW), .PROTECT(1'b0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .req(req), .we(we), .a(a), .wd(wd),
    .rd(rd_o[1]), .rd_valid(rdv_o[1]), .ready(rdy_o[1]), .err(err_o[1]));

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_init();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < DEPTH; k++)
        mdl_mem[i][k] = (k < KW) ? DW'(KERN[k]) : '0;
  endfunction

  // One clock of stimulus; the model reacts to what is accepted at the coming edge.
  task automatic cycle(input logic r, input logic w, input logic [AW-1:0] addr,
                       input logic [DW-1:0] d, input logic ini);
    int    nbusy;
    resp_t x;
    req = r; we = w; a = addr; wd = d; init_req = ini;
    nbusy = (busy > 0) ? busy - 1 : 0;
    if (busy == 0) begin
      if (ini) begin
        model_init();
        nbusy = DEPTH;
      end else if (r) begin
        for (int i = 0; i < 2; i++) begin
          if (int'(addr) >= DEPTH) begin
            x.is_err = 1'b1; x.chk_rd = 1'b1; x.data = '0;
            sb_q[i].push_back(x);
          end else if (w && i == 0 && int'(addr) < KW) begin
            x.is_err = 1'b1; x.chk_rd = 1'b0; x.data = '0;
            sb_q[i].push_back(x);
          end else if (w) begin
            mdl_mem[i][int'(addr)] = d;
          end else begin
            x.is_err = 1'b0; x.chk_rd = 1'b1; x.data = mdl_mem[i][int'(addr)];
            sb_q[i].push_back(x);
          end
        end
      end
    end
    @(posedge clk);
    busy = nbusy;
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic rdw(input int addr);
    cycle(1'b1, 1'b0, AW'(addr), '0, 1'b0);
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] d);
    cycle(1'b1, 1'b1, addr, d, 1'b0);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        last_rd[i] = '0;
      end else begin
        chk($sformatf("ready[%0d]", i), 32'(rdy_o[i]), 32'(busy == 0));
        chk($sformatf("excl[%0d]", i), 32'(rdv_o[i] & err_o[i]), 32'd0);
        if (rdv_o[i] || err_o[i]) begin
          if (sb_q[i].size() == 0) begin
            chk($sformatf("unexpected_out[%0d]", i), 32'(rdv_o[i] | err_o[i]), 32'd0);
          end else begin
            e = sb_q[i].pop_front();
            chk($sformatf("err[%0d]", i), 32'(err_o[i]), 32'(e.is_err));
            chk($sformatf("rd_valid[%0d]", i), 32'(rdv_o[i]), 32'(!e.is_err));
            if (e.chk_rd) last_rd[i] = e.data;
            chk($sformatf("rd[%0d]", i), 32'(rd_o[i]), 32'(last_rd[i]));
          end
        end else begin
          chk($sformatf("rd_hold[%0d]", i), 32'(rd_o[i]), 32'(last_rd[i]));
        end
      end
    end
  end

  initial begin
    logic          r, w, ini;
    logic [AW-1:0] addr;
    rst_n = 1'b0; init_req = 1'b0; req = 1'b0; we = 1'b0; a = '0; wd = '0;
    busy = DEPTH;
    model_init();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_rd[%0d]", i), 32'(rd_o[i]), 32'd0);
      chk($sformatf("rst_rdv[%0d]", i), 32'(rdv_o[i]), 32'd0);
      chk($sformatf("rst_err[%0d]", i), 32'(err_o[i]), 32'd0);
      chk($sformatf("rst_ready[%0d]", i), 32'(rdy_o[i]), 32'd0);
    end
    rst_n = 1'b1;
    repeat (DEPTH) idle();

    rdw(4); rdw(13); rdw(1); rdw(40);
    wr(24'd20, 24'h123456); rdw(20);
    wr(24'd4, 24'h000007); rdw(4);
    rdw(64); wr(24'h800000, 24'h55AA55); rdw(DEPTH + 3);
    wr(24'd30, 24'hABCDEF);
    cycle(1'b1, 1'b1, 24'd31, 24'h111111, 1'b1);
    repeat (DEPTH) idle();
    rdw(30); rdw(9); rdw(31); rdw(0);

    for (int n = 0; n < 800; n++) begin
      r   = ($urandom_range(0, 3) != 0);
      w   = 1'($urandom_range(0, 1));
      ini = ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 9))
        0:       addr = AW'($urandom);
        1:       addr = AW'($urandom_range(DEPTH, DEPTH + 3));
        2, 3:    addr = AW'($urandom_range(0, KW - 1));
        default: addr = AW'($urandom_range(0, DEPTH - 1));
      endcase
      cycle(r, w, addr, DW'($urandom), ini);
    end
    repeat (DEPTH + 2) idle();

    wr(24'd50, 24'hC0FFEE); rdw(50); idle();
    cycle(1'b0, 1'b0, '0, '0, 1'b1);
    repeat (10) idle();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("abort_rd[%0d]", i), 32'(rd_o[i]), 32'd0);
      chk($sformatf("abort_rdv[%0d]", i), 32'(rdv_o[i]), 32'd0);
      chk($sformatf("abort_err[%0d]", i), 32'(err_o[i]), 32'd0);
      chk($sformatf("abort_ready[%0d]", i), 32'(rdy_o[i]), 32'd0);
    end
    model_init();
    busy = DEPTH;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (DEPTH) idle();
    for (int k = 0; k < KW; k++) rdw(k);
    rdw(50); rdw(DEPTH - 1);
    repeat (3) idle();

    for (int i = 0; i < 2; i++)
      chk($sformatf("drain[%0d]", i), 32'(sb_q[i].size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
